dmem_responder: RTL

//   Memory-side responder for the pipeline's MEM-stage data port, using a valid/ready request/response protocol.

---
 rtl/dmem_responder.sv | 108 ++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage port: one outstanding
// 64-bit load/store, response after a fixed LATENCY, valid/ready handshakes.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [31:0]   cnt;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          addr_err;
    logic          accept;
    logic [63:0]   acc_rdata;
    logic [63:0]   rdata_p0;
    logic          err_p0;

    assign idx       = req_addr[3 +: AW];
    assign addr_err  = (req_addr[2:0] != 3'b0) || (req_addr[63:3+AW] != '0);
    assign accept    = resetl && (state == IDLE) && req_ready && req_valid;
    assign acc_rdata = (req_write || addr_err) ? 64'd0 : mem[idx];

    // Array is never cleared, so a committed store survives a later reset.
    always_ff @(posedge CLK) begin
        if (accept && req_write && !addr_err)
            mem[idx] <= req_wdata;
    end

    // Accept edge -> p0: read data and error captured, held until response.
    always_ff @(posedge CLK) begin
        if (accept) begin
            rdata_p0 <= acc_rdata;
            err_p0   <= addr_err;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            cnt        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            cnt   <= 32'd1;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= acc_rdata;
                            resp_err   <= addr_err;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt >= 32'(LATENCY - 1)) begin
                        state      <= RESP;
                        cnt        <= 32'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_p0;
                        resp_err   <= err_p0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESP: begin
                    // req_ready rises only after the handshake edge.
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 64'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
